// File: rtl/reg_share_arb.sv
// Round-robin arbiter giving four requesters write access to one shared register.
// Each access is a three-cycle IDLE -> GRANT -> ACK handshake; GRANT aborts if the winner drops req.
module reg_share_arb #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   clr,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   q,
    output logic           busy,
    output logic [7:0]     wr_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   win_q, win_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [N-1:0] ack_q, ack_d;
    logic [W-1:0] q_q, q_d;
    logic [7:0]   wr_cnt_q, wr_cnt_d;

    logic [1:0]   rr_idx;
    logic [1:0]   rr_win;
    logic         rr_found;

    // Search starts at ptr and wraps; the first asserted request wins.
    always_comb begin
        rr_win   = 2'd0;
        rr_found = 1'b0;
        rr_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            rr_idx = ptr_q + 2'(i);
            if (!rr_found && req[rr_idx]) begin
                rr_win   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = '0;
        ack_d    = '0;
        q_d      = q_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    win_d        = rr_win;
                    gnt_d[rr_win] = 1'b1;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                // A winner that dropped req forfeits the slot without moving ptr.
                if (req[win_q]) begin
                    q_d          = clr[win_q] ? '0 : wdata[win_q*W +: W];
                    ack_d[win_q] = 1'b1;
                    wr_cnt_d     = wr_cnt_q + 8'd1;
                    ptr_d        = win_q + 2'd1;
                    state_d      = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            win_q    <= 2'd0;
            gnt_q    <= '0;
            ack_q    <= '0;
            q_q      <= '0;
            wr_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            q_q      <= q_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign q      = q_q;
    assign wr_cnt = wr_cnt_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed self-checking bench for reg_share_arb: single write, round-robin order,
// clear, abort, mid-GRANT reset and write-counter wrap.
module tb_reg_share_arb;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   clr;
    logic [4*W-1:0] wdata;
    logic [3:0]   gnt;
    logic [3:0]   ack;
    logic [W-1:0] q;
    logic         busy;
    logic [7:0]   wr_cnt;

    int n_checks;
    int n_pass;

    reg_share_arb #(.W(W), .N(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .clr    (clr),
        .wdata  (wdata),
        .gnt    (gnt),
        .ack    (ack),
        .q      (q),
        .busy   (busy),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkAll(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                            input logic [7:0] e_q, input logic [7:0] e_cnt, input logic e_busy);
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        checkOutput({tag, ".ack"}, 32'(ack), 32'(e_ack));
        checkOutput({tag, ".q"}, 32'(q), 32'(e_q));
        checkOutput({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(e_cnt));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        logic [3:0] exp_oh;
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b0;
        req   = 4'b0000;
        clr   = 4'b0000;
        wdata = '0;

        applyStimulus();
        applyStimulus();
        checkAll("reset", 4'b0000, 4'b0000, 8'h00, 8'd0, 1'b0);

        // Single write from requester 0.
        rst = 1'b1;
        req = 4'b0001;
        wdata[0*W +: W] = 8'hA5;
        applyStimulus();
        checkAll("w0_grant", 4'b0001, 4'b0000, 8'h00, 8'd0, 1'b1);
        applyStimulus();
        checkAll("w0_ack", 4'b0000, 4'b0001, 8'hA5, 8'd1, 1'b1);
        req = 4'b0000;
        applyStimulus();
        checkAll("w0_idle", 4'b0000, 4'b0000, 8'hA5, 8'd1, 1'b0);

        // Requester 1 drops req during GRANT; ptr stays at 1.
        req = 4'b0010;
        wdata[1*W +: W] = 8'h77;
        applyStimulus();
        checkAll("ab_grant", 4'b0010, 4'b0000, 8'hA5, 8'd1, 1'b1);
        req = 4'b0000;
        applyStimulus();
        checkAll("ab_abort", 4'b0000, 4'b0000, 8'hA5, 8'd1, 1'b0);
        req = 4'b0011;
        wdata[1*W +: W] = 8'h3C;
        applyStimulus();
        checkAll("ab_regrant1", 4'b0010, 4'b0000, 8'hA5, 8'd1, 1'b1);
        applyStimulus();
        checkAll("ab_ack1", 4'b0000, 4'b0010, 8'h3C, 8'd2, 1'b1);
        req = 4'b0001;
        wdata[0*W +: W] = 8'hFF;
        applyStimulus();
        checkAll("ab_ackdone", 4'b0000, 4'b0000, 8'h3C, 8'd2, 1'b0);
        applyStimulus();
        checkAll("ab_grant0", 4'b0001, 4'b0000, 8'h3C, 8'd2, 1'b1);
        applyStimulus();
        checkAll("ab_ack0", 4'b0000, 4'b0001, 8'hFF, 8'd3, 1'b1);
        req = 4'b0000;
        applyStimulus();

        // Clear from requester 2 while q holds 0xFF; wdata must be ignored.
        req = 4'b0100;
        clr = 4'b0100;
        wdata[2*W +: W] = 8'h5A;
        applyStimulus();
        checkAll("clr_grant", 4'b0100, 4'b0000, 8'hFF, 8'd3, 1'b1);
        applyStimulus();
        checkAll("clr_ack", 4'b0000, 4'b0100, 8'h00, 8'd4, 1'b1);
        req = 4'b0000;
        clr = 4'b0000;
        applyStimulus();
        checkAll("clr_idle", 4'b0000, 4'b0000, 8'h00, 8'd4, 1'b0);

        // Reset lands while requester 3 is in GRANT.
        req = 4'b1000;
        wdata[3*W +: W] = 8'hC3;
        applyStimulus();
        checkAll("rg_grant", 4'b1000, 4'b0000, 8'h00, 8'd4, 1'b1);
        rst = 1'b0;
        applyStimulus();
        checkAll("rg_reset", 4'b0000, 4'b0000, 8'h00, 8'd0, 1'b0);

        // All four requesting from reset: grants rotate 0,1,2,3,0.
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) wdata[i*W +: W] = 8'h10 + 8'(i);
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            applyStimulus();
            checkAll($sformatf("rr%0d_grant", k), exp_oh, 4'b0000,
                     (k == 0) ? 8'h00 : 8'h10 + 8'((k - 1) % 4), 8'(k), 1'b1);
            applyStimulus();
            checkAll($sformatf("rr%0d_ack", k), 4'b0000, exp_oh, 8'h10 + 8'(k % 4), 8'(k + 1), 1'b1);
            applyStimulus();
            checkAll($sformatf("rr%0d_idle", k), 4'b0000, 4'b0000, 8'h10 + 8'(k % 4), 8'(k + 1), 1'b0);
        end

        // 256 completed writes from reset wrap the counter to zero.
        req = 4'b0000;
        rst = 1'b0;
        applyStimulus();
        rst = 1'b1;
        req = 4'b0001;
        wdata[0*W +: W] = 8'h99;
        for (int k = 0; k < 256; k++) begin
            applyStimulus();
            applyStimulus();
            if (k == 254) checkOutput("wrap_cnt255", 32'(wr_cnt), 32'd255);
            applyStimulus();
        end
        req = 4'b0000;
        checkAll("wrap_zero", 4'b0000, 4'b0000, 8'h99, 8'd0, 1'b0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 Parameter W, default 8, data width of the shared register.
REQ-002 Parameter N, fixed at 4, number of requesters; other values are unsupported.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-low (asserted when 0, sampled on posedge clk).
REQ-005 req  input  4  per-requester access request; bit i belongs to requester i.
REQ-006 clr  input  4  per-requester clear qualifier; clr[i]=1 with req[i] requests a write of 0.
REQ-007 wdata  input  4*W  per-requester write data; requester i owns bits [i*W +: W].
REQ-008 gnt  output  4  one-hot grant, registered.
REQ-009 ack  output  4  one-hot completion pulse, registered, one cycle wide.
REQ-010 q  output  W  shared register contents.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 wr_cnt  output  8  count of completed writes, including clears.

Function
REQ-013 FSM states SHALL be IDLE, GRANT and ACK.
REQ-014 IDLE with req==0 -> stay in IDLE; gnt=0, ack=0.
REQ-015 IDLE with req!=0 -> select a winner round-robin; next cycle set gnt[winner]=1, state GRANT.
REQ-016 Round-robin search order SHALL be ptr, ptr+1, ptr+2, ptr+3 (mod 4); first asserted req wins.
REQ-017 ptr (2 bit) SHALL become winner+1 mod 4 only on a completed write; it is unchanged on an abort.
REQ-018 GRANT with req[winner]=1 -> q <= clr[winner] ? 0 : wdata[winner]; gnt <= 0; ack[winner] <= 1; state ACK.
REQ-019 GRANT with req[winner]=0 -> abort: q unchanged, no ack, wr_cnt unchanged, gnt <= 0, state IDLE.
REQ-020 ACK -> ack <= 0, state IDLE unconditionally; no arbitration happens in ACK.
REQ-021 clr and wdata SHALL be sampled only in GRANT; values in other states are ignored.
REQ-022 q SHALL change only on a completed GRANT cycle; q holds in all other cycles.
REQ-023 wr_cnt SHALL increment by 1 on each completed write and wrap from 255 to 0.
REQ-024 Latency: req sampled at edge k -> gnt high after k, q updated and ack high after k+1, IDLE after k+2.
REQ-025 Maximum throughput SHALL be one write per 3 cycles.
REQ-026 Requesters SHALL hold req[i] until ack[i]; req[i] may stay high after ack and is then re-arbitrated from IDLE.
REQ-027 New req bits asserted during GRANT or ACK SHALL be ignored until the next IDLE.
REQ-028 At most one bit of gnt and one bit of ack SHALL be high in any cycle; gnt and ack are never both nonzero.

Reset
REQ-029 With rst=0 at a posedge: state=IDLE, ptr=0, gnt=0, ack=0, q=0, wr_cnt=0, busy=0.
REQ-030 Reset SHALL override any state, including mid-GRANT, with no write and no ack.
REQ-031 Arbitration SHALL resume on the first posedge with rst=1.

Verification
REQ-032 Reset, then req=0001, wdata[0]=0xA5 -> gnt=0001 one cycle, then q=0xA5, ack=0001 one cycle, wr_cnt=1.
REQ-033 req=1111 held continuously from reset -> grants in order 0,1,2,3,0, one every 3 cycles; each ack pulse is one cycle wide.
REQ-034 req=0100 with clr=0100 while q=0xFF -> q=0x00 after the GRANT cycle, ack=0100, wr_cnt increments.
REQ-035 req[1] dropped during GRANT -> q unchanged, no ack, ptr unchanged; next req=0011 grants requester 1 first (ptr=1 after an earlier ack of requester 0).
REQ-036 rst=0 asserted during GRANT -> next cycle gnt=0, ack=0, q=0, wr_cnt=0, state IDLE.
REQ-037 256 completed writes from reset -> wr_cnt wraps to 0.
